hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised stall/flush controller for the non-forwarding RV32I pipeline; next generation of the fixed-window staller.
//  Tracks in-flight destination registers with per-register countdown counters instead of comparing fixed stage pairs.
//  Sits beside the ID stage: holds IF/ID on RAW hazards and FENCE drains, and kills IF/ID for a configurable number of cycles after a taken branch or jump.
// PARAMETERS
//  DATA_WIDTH  32  instruction width
//  WB_DIST     3   cycles from ID issue until the result is readable in ID (write-first regfile); range 1..15
//  BR_FLUSH    1   cycles flush_o stays high per taken branch/jump; range 1..7
//  CNT_WIDTH   32  perf counter width (HAZARD_PERF_EN only)
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_ni         in   1           reset, synchronous, active-low
//  id_inst_i      in   DATA_WIDTH  instruction in ID
//  id_valid_i     in   1           id_inst_i is a real instruction (not a bubble)
//  br_taken_i     in   1           branch/JAL/JALR in EX redirects the PC this cycle
//  stall_o        out  1           hold PC and IF/ID; inject a bubble into EX
//  flush_o        out  1           kill IF/ID contents
//  issue_o        out  1           ID instruction advances to EX this cycle
//  busy_o         out  1           at least one scoreboard counter is non-zero
// BEHAVIOUR
//  Decode (opcode [6:0]):
//  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
//  - rs2 used by BRANCH, STORE, OP.
//  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; rd=x0 never tracked.
//  - FENCE = 0001111.
//  Scoreboard: cnt[1..31], width $clog2(WB_DIST); all zero in reset.
//  - Every cycle, each non-zero counter decrements by 1.
//  - On issue_o with a tracked rd: cnt[rd] <= WB_DIST-1; the load overrides the decrement.
//  - WB_DIST=1: nothing is ever tracked and stall_o is never raised by a RAW hazard.
//  raw = id_valid_i & ((rs1 used & cnt[rs1]!=0) | (rs2 used & cnt[rs2]!=0)); x0 reads never hazard.
//  drain = id_valid_i & FENCE & busy_o.
//  FSM, two states:
//  - RUN: br_taken_i -> FLUSH, loading fl_cnt = BR_FLUSH-1. If BR_FLUSH=1, stay in RUN.
//  - FLUSH: fl_cnt decrements each cycle; -> RUN when fl_cnt==0.
//  - br_taken_i while in FLUSH reloads fl_cnt = BR_FLUSH-1.
//  Outputs (combinational from state and inputs):
//  - flush_o = br_taken_i | (state==FLUSH).
//  - stall_o = ~flush_o & (raw | drain).
//  - issue_o = id_valid_i & ~stall_o & ~flush_o. A flushed instruction never updates the scoreboard.
//  - Flush has priority over stall in the same cycle.
//  Latency: dependent in ID one cycle after its producer stalls WB_DIST-1 cycles, then issues.
//  Reset (rst_ni=0 at a clock edge): state RUN, all counters 0. While rst_ni is low, stall_o, flush_o and issue_o are forced to 0.
//  Reset mid-flush or mid-stall aborts immediately; no pending state survives.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//  - Adds output ports stall_cnt_o[CNT_WIDTH] (cycles with stall_o=1) and flush_cnt_o[CNT_WIDTH] (cycles with flush_o=1).
//  - Both counters saturate at all-ones and are cleared by reset.
//  HAZARD_PERF_EN undefined: these ports and their registers do not exist; all other behaviour is identical.
// TESTING
//  1. ID: addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333); WB_DIST=3 -> stall_o=1 for 2 cycles, issue_o=1 on the 3rd.
//  2. addi x0,x0,0 (0x00000013), then add x6,x0,x0 -> no stall; busy_o stays 0.
//  3. lui x5,1 then lui x6,1 -> no stall. Next, sw x5,0(x0) (rs2=x5) -> stall_o=1 for 1 cycle.
//  4. BR_FLUSH=2; br_taken_i pulsed 1 cycle while ID holds a RAW-dependent add:
//     -> flush_o=1 for 2 cycles, stall_o=0, issue_o=0, scoreboard unchanged.
//     Second br_taken_i pulse during FLUSH -> flush window extended by 2 cycles from that pulse.
//  5. addi x7,x0,1 issued, FENCE (0x0000000F) next in ID -> stall_o=1 until busy_o=0, then issue_o=1.
//  6. rst_ni=0 for 1 cycle during a RAW stall with flush pending -> next cycle busy_o=0, stall_o=0, flush_o=0.
//     With HAZARD_PERF_EN, stall_cnt_o=flush_cnt_o=0. Saturation check: CNT_WIDTH=4, hold stall 20 cycles -> stall_cnt_o=4'hF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Stall/flush controller for the non-forwarding RV32I pipeline using per-register countdown scoreboard.
// Optional perf counters (stall_cnt_o / flush_cnt_o) are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WB_DIST    = 3,
    parameter int unsigned BR_FLUSH   = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] id_inst_i,
    input  logic                  id_valid_i,
    input  logic                  br_taken_i,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  issue_o,
    output logic                  busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

    localparam int unsigned SB_W = (WB_DIST > 1) ? $clog2(WB_DIST) : 1;
    localparam int unsigned FL_W = 3;
    localparam logic [SB_W-1:0] SB_LOAD = SB_W'(WB_DIST - 1);
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(BR_FLUSH - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e          state_q;
    logic [FL_W-1:0] fl_cnt_q;
    logic [SB_W-1:0] cnt_q [32];

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       rs1_use, rs2_use, rd_use, is_fence;
    logic       rd_track, raw, drain, flush_c, stall_c, issue_c, busy_c;

    assign opcode = id_inst_i[6:0];
    assign rd     = id_inst_i[11:7];
    assign rs1    = id_inst_i[19:15];
    assign rs2    = id_inst_i[24:20];

    logic unused_bits;
    assign unused_bits = ^{id_inst_i[DATA_WIDTH-1:25], id_inst_i[14:12]};

    // Register usage decode by opcode
    always_comb begin
        rs1_use  = 1'b0;
        rs2_use  = 1'b0;
        rd_use   = 1'b0;
        is_fence = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: rd_use = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                rs1_use = 1'b1;
                rd_use  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
            end
            OP_OP: begin
                rs1_use = 1'b1;
                rs2_use = 1'b1;
                rd_use  = 1'b1;
            end
            OP_FENCE: is_fence = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            busy_c = busy_c | (cnt_q[i] != '0);
        end
    end

    // x0 entry is held at zero, so x0 reads never hazard
    assign raw      = id_valid_i & ((rs1_use & (cnt_q[rs1] != '0)) |
                                    (rs2_use & (cnt_q[rs2] != '0)));
    assign drain    = id_valid_i & is_fence & busy_c;
    assign flush_c  = rst_ni & (br_taken_i | (state_q == FLUSH));
    assign stall_c  = rst_ni & ~flush_c & (raw | drain);
    assign issue_c  = rst_ni & id_valid_i & ~stall_c & ~flush_c;
    assign rd_track = rd_use & (rd != 5'd0) & (WB_DIST > 1);

    assign stall_o = stall_c;
    assign flush_o = flush_c;
    assign issue_o = issue_c;
    assign busy_o  = busy_c;

    // Scoreboard: a fresh issue reloads its rd, otherwise counters count down
    always_ff @(posedge clk_i) begin
        cnt_q[0] <= '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (!rst_ni) begin
                cnt_q[i] <= '0;
            end else if (issue_c && rd_track && (rd == 5'(i))) begin
                cnt_q[i] <= SB_LOAD;
            end else if (cnt_q[i] != '0) begin
                cnt_q[i] <= cnt_q[i] - SB_W'(1);
            end
        end
    end

    // Flush window FSM: fl_cnt holds the remaining FLUSH-state cycles
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            fl_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (br_taken_i && (BR_FLUSH > 1)) begin
                        state_q  <= FLUSH;
                        fl_cnt_q <= FL_LOAD;
                    end
                end
                FLUSH: begin
                    if (br_taken_i) begin
                        fl_cnt_q <= FL_LOAD;
                    end else if (fl_cnt_q <= FL_W'(1)) begin
                        state_q  <= RUN;
                        fl_cnt_q <= '0;
                    end else begin
                        fl_cnt_q <= fl_cnt_q - FL_W'(1);
                    end
                end
                default: begin
                    state_q  <= RUN;
                    fl_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_c && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            if (flush_c && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
        end
    end
`else
    localparam int unsigned unused_cnt_width = CNT_WIDTH;
`endif

endmodule
